// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one Hyperbus native controller port between NPORTS requesters.
// Each grant covers a fixed BEATS-beat transaction; a watchdog aborts transfers that stall.
module hyperbus_arbiter #(
   parameter int unsigned NPORTS          = 2,
   parameter int unsigned HBUS_ADDR_WIDTH = 32,
   parameter int unsigned HBUS_DATA_WIDTH = 16,
   parameter int unsigned BEATS           = 2,
   parameter int unsigned TIMEOUT         = 1024
) (
   input  logic                                hbus_clk,
   input  logic                                hbus_rst,
   input  logic [NPORTS-1:0]                   req_rrq,
   input  logic [NPORTS-1:0]                   req_wrq,
   input  logic [NPORTS*HBUS_ADDR_WIDTH-1:0]   req_adr_i,
   input  logic [NPORTS*HBUS_DATA_WIDTH-1:0]   req_dat_i,
   output logic [HBUS_DATA_WIDTH-1:0]          req_dat_o,
   output logic [NPORTS-1:0]                   req_gnt,
   output logic [NPORTS-1:0]                   req_ready,
   output logic [NPORTS-1:0]                   req_valid,
   output logic [NPORTS-1:0]                   req_done,
   output logic [NPORTS-1:0]                   req_err,
   output logic [HBUS_ADDR_WIDTH-1:0]          hbus_adr_o,
   output logic [HBUS_DATA_WIDTH-1:0]          hbus_dat_o,
   input  logic [HBUS_DATA_WIDTH-1:0]          hbus_dat_i,
   output logic                                hbus_rrq,
   output logic                                hbus_wrq,
   input  logic                                hbus_ready,
   input  logic                                hbus_valid,
   input  logic                                hbus_busy
);

   localparam int unsigned AW = HBUS_ADDR_WIDTH;
   localparam int unsigned DW = HBUS_DATA_WIDTH;
   localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int unsigned WW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [7:0]      cnt;
   logic [WW-1:0]   wdog;
   logic            is_read;
   logic            aborted;

   logic            any_req;
   logic            hi_found;
   logic [PW-1:0]   hi_idx;
   logic [PW-1:0]   lo_idx;
   logic [PW-1:0]   win;
   logic [NPORTS-1:0] win_oh;
   logic [AW-1:0]   sel_adr;
   logic            win_rd;
   logic            in_xfer;
   logic            beat;

   // Lowest requester above the pointer wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      any_req  = |(req_rrq | req_wrq);
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
         if (req_rrq[p] || req_wrq[p]) begin
            lo_idx = PW'(p);
            if (p > int'(ptr)) begin
               hi_idx   = PW'(p);
               hi_found = 1'b1;
            end
         end
      end
      win = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      win_oh  = '0;
      sel_adr = '0;
      win_rd  = 1'b0;
      for (int p = 0; p < int'(NPORTS); p++) begin
         if (win == PW'(p)) begin
            win_oh[p] = 1'b1;
            sel_adr   = req_adr_i[p*AW +: AW];
            win_rd    = req_rrq[p];
         end
      end
   end

   always_comb begin
      hbus_dat_o = '0;
      for (int p = 0; p < int'(NPORTS); p++) begin
         if (req_gnt[p]) begin
            hbus_dat_o = hbus_dat_o | req_dat_i[p*DW +: DW];
         end
      end
   end

   assign in_xfer   = (state == StXfer);
   assign beat      = in_xfer && (is_read ? hbus_valid : hbus_ready);
   assign req_dat_o = hbus_dat_i;
   assign req_valid = req_gnt & {NPORTS{hbus_valid & in_xfer & is_read}};
   assign req_ready = req_gnt & {NPORTS{hbus_ready & in_xfer & ~is_read}};

   always_ff @(posedge hbus_clk or posedge hbus_rst) begin
      if (hbus_rst) begin
         state      <= StIdle;
         ptr        <= PW'(NPORTS - 1);
         cnt        <= '0;
         wdog       <= '0;
         is_read    <= 1'b0;
         aborted    <= 1'b0;
         req_gnt    <= '0;
         req_done   <= '0;
         req_err    <= '0;
         hbus_rrq   <= 1'b0;
         hbus_wrq   <= 1'b0;
         hbus_adr_o <= '0;
      end else begin
         hbus_rrq <= 1'b0;
         hbus_wrq <= 1'b0;
         req_done <= '0;
         req_err  <= '0;
         case (state)
            StIdle: begin
               if (!hbus_busy && any_req) begin
                  state      <= StXfer;
                  req_gnt    <= win_oh;
                  hbus_adr_o <= sel_adr;
                  is_read    <= win_rd;
                  cnt        <= 8'(BEATS);
                  wdog       <= '0;
                  aborted    <= 1'b0;
                  ptr        <= win;
                  hbus_rrq   <= win_rd;
                  hbus_wrq   <= ~win_rd;
               end
            end
            StXfer: begin
               // A beat always wins over the watchdog, even on its final cycle.
               if (beat) begin
                  cnt  <= cnt - 8'd1;
                  wdog <= '0;
                  if (cnt == 8'd1) begin
                     state <= StDrain;
                  end
               end else if (wdog == WW'(TIMEOUT - 1)) begin
                  req_err <= req_gnt;
                  aborted <= 1'b1;
                  state   <= StDrain;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            StDrain: begin
               if (!hbus_busy) begin
                  req_done <= aborted ? '0 : req_gnt;
                  req_gnt  <= '0;
                  state    <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Scoreboard bench for hyperbus_arbiter: stimulus queues expected bus events, a negedge
// monitor pops and compares them as the DUT presents issues, beats, done and err pulses.
module tb_hyperbus_arbiter;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 16;
   localparam int TO = 8;

   localparam int K_RISS  = 1;
   localparam int K_WISS  = 2;
   localparam int K_RBEAT = 3;
   localparam int K_WBEAT = 4;
   localparam int K_ERR   = 5;
   localparam int K_DONE  = 6;

   typedef struct {
      int          kind;
      int          port;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   logic              hbus_clk = 1'b0;
   logic              hbus_rst;
   logic [NP-1:0]     req_rrq;
   logic [NP-1:0]     req_wrq;
   logic [NP*AW-1:0]  req_adr_i;
   logic [NP*DW-1:0]  req_dat_i;
   logic [DW-1:0]     req_dat_o;
   logic [NP-1:0]     req_gnt;
   logic [NP-1:0]     req_ready;
   logic [NP-1:0]     req_valid;
   logic [NP-1:0]     req_done;
   logic [NP-1:0]     req_err;
   logic [AW-1:0]     hbus_adr_o;
   logic [DW-1:0]     hbus_dat_o;
   logic [DW-1:0]     hbus_dat_i;
   logic              hbus_rrq;
   logic              hbus_wrq;
   logic              hbus_ready;
   logic              hbus_valid;
   logic              hbus_busy;

   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;
   ev_t exp_q[$];

   hyperbus_arbiter #(
      .NPORTS          (NP),
      .HBUS_ADDR_WIDTH (AW),
      .HBUS_DATA_WIDTH (DW),
      .BEATS           (2),
      .TIMEOUT         (TO)
   ) dut (
      .hbus_clk   (hbus_clk),
      .hbus_rst   (hbus_rst),
      .req_rrq    (req_rrq),
      .req_wrq    (req_wrq),
      .req_adr_i  (req_adr_i),
      .req_dat_i  (req_dat_i),
      .req_dat_o  (req_dat_o),
      .req_gnt    (req_gnt),
      .req_ready  (req_ready),
      .req_valid  (req_valid),
      .req_done   (req_done),
      .req_err    (req_err),
      .hbus_adr_o (hbus_adr_o),
      .hbus_dat_o (hbus_dat_o),
      .hbus_dat_i (hbus_dat_i),
      .hbus_rrq   (hbus_rrq),
      .hbus_wrq   (hbus_wrq),
      .hbus_ready (hbus_ready),
      .hbus_valid (hbus_valid),
      .hbus_busy  (hbus_busy)
   );

   always #5 hbus_clk = ~hbus_clk;

   always @(posedge hbus_clk) cyc <= cyc + 1;

   function automatic int oh2idx(input logic [NP-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NP; i++) begin
         if (v[i]) r = (r == -1) ? i : 99;
      end
      return r;
   endfunction

   function automatic string kname(input int k);
      case (k)
         K_RISS:  return "rd_issue";
         K_WISS:  return "wr_issue";
         K_RBEAT: return "rd_beat";
         K_WBEAT: return "wr_beat";
         K_ERR:   return "err";
         K_DONE:  return "done";
         default: return "unknown";
      endcase
   endfunction

   task automatic exp_push(input int kind, input int port, input logic [31:0] data,
                           input int at);
      ev_t e;
      e.kind = kind;
      e.port = port;
      e.data = data;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int port, input logic [31:0] data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s: got port=%0d data=%h cyc=%0d, required none",
                  kname(kind), port, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.port != port || e.data !== data || e.cyc != cyc) begin
            failures++;
            $display("FAIL %s: got %s port=%0d data=%h cyc=%0d, required %s port=%0d data=%h cyc=%0d",
                     kname(e.kind), kname(kind), port, data, cyc,
                     kname(e.kind), e.port, e.data, e.cyc);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: fixed per-cycle order issue, rd beat, wr beat, err, done.
   always @(negedge hbus_clk) begin
      if (!hbus_rst) begin
         if (hbus_rrq || hbus_wrq)
            observe(hbus_rrq ? K_RISS : K_WISS, oh2idx(req_gnt), hbus_adr_o);
         if (req_valid != '0) observe(K_RBEAT, oh2idx(req_valid), 32'(req_dat_o));
         if (req_ready != '0) observe(K_WBEAT, oh2idx(req_ready), 32'(hbus_dat_o));
         if (req_err != '0)   observe(K_ERR, oh2idx(req_err), 32'h0);
         if (req_done != '0)  observe(K_DONE, oh2idx(req_done), 32'h0);
      end
   end

   task automatic tick();
      @(posedge hbus_clk);
      #1;
   endtask

   task automatic rd_beat(input int port, input logic [15:0] d);
      hbus_valid = 1'b1;
      hbus_dat_i = d;
      exp_push(K_RBEAT, port, 32'(d), cyc);
      tick();
   endtask

   initial begin
      hbus_rst   = 1'b1;
      req_rrq    = '0;
      req_wrq    = '0;
      req_adr_i  = '0;
      req_dat_i  = {16'h5A5A, 16'hC3C3};
      hbus_dat_i = '0;
      hbus_valid = 1'b1;
      hbus_ready = 1'b1;
      hbus_busy  = 1'b0;
      tick();
      tick();
      chk("rst_gnt",    32'(req_gnt), 32'h0);
      chk("rst_rrq",    32'(hbus_rrq), 32'h0);
      chk("rst_wrq",    32'(hbus_wrq), 32'h0);
      chk("rst_adr",    hbus_adr_o, 32'h0);
      chk("rst_dat_o",  32'(hbus_dat_o), 32'h0);
      chk("rst_valid",  32'(req_valid), 32'h0);
      chk("rst_ready",  32'(req_ready), 32'h0);
      chk("rst_done",   32'(req_done | req_err), 32'h0);
      hbus_valid = 1'b0;
      hbus_ready = 1'b0;
      hbus_rst   = 1'b0;

      // Single read on port 0, first beat in the issue cycle.
      req_adr_i[0 +: AW] = 32'h1000;
      req_rrq = 2'b01;
      exp_push(K_RISS, 0, 32'h1000, cyc + 1);
      tick();
      req_rrq   = '0;
      hbus_busy = 1'b1;
      rd_beat(0, 16'hAAAA);
      hbus_valid = 1'b0;
      hbus_ready = 1'b1;                       // wrong direction
      tick();
      hbus_ready = 1'b0;
      rd_beat(0, 16'hBBBB);
      hbus_dat_i = 16'hCCCC;                   // still valid in DRAIN: ignored
      tick();
      hbus_valid = 1'b0;
      tick();
      hbus_busy = 1'b0;
      exp_push(K_DONE, 0, 32'h0, cyc + 1);
      tick();
      tick();
      chk("idle_dat_o", 32'(hbus_dat_o), 32'h0);

      // Single write on port 1, write data routed live from the granted port.
      req_adr_i[AW +: AW] = 32'h20;
      req_dat_i[DW +: DW] = 16'h1234;
      req_wrq = 2'b10;
      exp_push(K_WISS, 1, 32'h20, cyc + 1);
      tick();
      req_wrq    = '0;
      hbus_busy  = 1'b1;
      hbus_valid = 1'b1;                       // wrong direction
      tick();
      chk("wr_dat_o", 32'(hbus_dat_o), 32'h1234);
      hbus_valid = 1'b0;
      hbus_ready = 1'b1;
      exp_push(K_WBEAT, 1, 32'h1234, cyc);
      tick();
      hbus_ready = 1'b0;
      tick();
      hbus_ready = 1'b1;
      req_dat_i[DW +: DW] = 16'h5678;
      exp_push(K_WBEAT, 1, 32'h5678, cyc);
      tick();
      hbus_ready = 1'b0;
      hbus_busy  = 1'b0;
      exp_push(K_DONE, 1, 32'h0, cyc + 1);
      tick();
      tick();

      // Round-robin: both ports hold requests; port 1 holds rrq and wrq (read wins).
      req_adr_i[0 +: AW]  = 32'h100;
      req_adr_i[AW +: AW] = 32'h200;
      req_rrq = 2'b11;
      req_wrq = 2'b10;
      exp_push(K_RISS, 0, 32'h100, cyc + 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         rd_beat(k % 2, 16'(16'h0101 * (k + 1)));
         rd_beat(k % 2, 16'(16'h1010 * (k + 1)));
         hbus_valid = 1'b0;
         exp_push(K_DONE, k % 2, 32'h0, cyc + 1);
         if (k < 3) begin
            exp_push(K_RISS, (k + 1) % 2, (k % 2 == 0) ? 32'h200 : 32'h100, cyc + 2);
         end else begin
            req_rrq = '0;
            req_wrq = '0;
         end
         tick();
      end
      tick();

      // Busy gating.
      hbus_busy = 1'b1;
      req_adr_i[0 +: AW] = 32'h300;
      req_rrq = 2'b01;
      tick();
      tick();
      tick();
      chk("busy_gnt", 32'(req_gnt), 32'h0);
      chk("busy_rrq", 32'(hbus_rrq), 32'h0);
      hbus_busy = 1'b0;
      exp_push(K_RISS, 0, 32'h300, cyc + 1);
      tick();
      req_rrq = '0;
      rd_beat(0, 16'h1111);
      rd_beat(0, 16'h2222);
      hbus_valid = 1'b0;
      exp_push(K_DONE, 0, 32'h0, cyc + 1);
      tick();
      tick();

      // Timeout: write with no hbus_ready aborts after TO cycles in XFER.
      req_adr_i[AW +: AW] = 32'h40;
      req_wrq = 2'b10;
      exp_push(K_WISS, 1, 32'h40, cyc + 1);
      tick();
      req_wrq = '0;
      exp_push(K_ERR, 1, 32'h0, cyc + TO);
      repeat (TO) tick();
      req_adr_i[0 +: AW] = 32'h600;
      req_rrq = 2'b01;
      exp_push(K_RISS, 0, 32'h600, cyc + 2);
      tick();
      tick();
      req_rrq = '0;
      // Beat lands exactly when the watchdog is at TO-1: counted, no abort.
      repeat (TO - 1) tick();
      rd_beat(0, 16'h7777);
      rd_beat(0, 16'h8888);
      hbus_valid = 1'b0;
      exp_push(K_DONE, 0, 32'h0, cyc + 1);
      tick();
      tick();

      // Reset mid-transfer.
      req_adr_i[0 +: AW] = 32'h500;
      req_dat_i[0 +: DW] = 16'hABCD;
      req_rrq = 2'b01;
      exp_push(K_RISS, 0, 32'h500, cyc + 1);
      tick();
      req_rrq   = '0;
      hbus_busy = 1'b1;
      rd_beat(0, 16'h9999);
      hbus_rst = 1'b1;
      #1;
      chk("mid_rst_gnt",   32'(req_gnt), 32'h0);
      chk("mid_rst_rrq",   32'(hbus_rrq | hbus_wrq), 32'h0);
      chk("mid_rst_adr",   hbus_adr_o, 32'h0);
      chk("mid_rst_dat_o", 32'(hbus_dat_o), 32'h0);
      chk("mid_rst_valid", 32'(req_valid), 32'h0);
      tick();
      tick();
      hbus_rst   = 1'b0;
      hbus_valid = 1'b0;
      hbus_busy  = 1'b0;
      req_adr_i[0 +: AW]  = 32'h510;
      req_adr_i[AW +: AW] = 32'h520;
      req_rrq = 2'b11;
      exp_push(K_RISS, 0, 32'h510, cyc + 1);
      tick();
      req_rrq = '0;
      rd_beat(0, 16'h4321);
      rd_beat(0, 16'h8765);
      hbus_valid = 1'b0;
      exp_push(K_DONE, 0, 32'h0, cyc + 1);
      tick();
      tick();
      tick();

      chk("pending_events", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
